fxyz_sweep_ctrl: RTL



---
 rtl/fxyz_sweep_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/fxyz_sweep_ctrl.sv
// fxyz_sweep_ctrl: walks the 3-input function block fxyz through vectors 0..7
// (x = MSB, z = LSB). It samples s once per vector and builds an 8-bit minterm
// mask plus a ones count.
// Optional build macro FXYZ_CHECK_EN: compares the final mask with EXPECT_MASK
// and drives mismatch. Without it, mismatch is tied low.
//
// state  | meaning
// IDLE   | outputs parked at 0, waiting for start; mask/ones/mismatch held
// RUN    | {x,y,z} = idx, each vector held SETTLE cycles, s sampled on last one
// FINISH | single-cycle done pulse, mask/ones final
module fxyz_sweep_ctrl #(
   parameter int          SETTLE      = 1,
   parameter logic [7:0]  EXPECT_MASK = 8'h54
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   output logic       x,
   output logic       y,
   output logic       z,
   input  logic       s_in,
   output logic       busy,
   output logic       done,
   output logic [7:0] mask,
   output logic [3:0] ones,
   output logic       mismatch
);

   // A SETTLE of 0 would never sample, so it is promoted to 1.
   localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
   localparam int CW         = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_EFF - 1);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t        state, state_nxt;
   logic [2:0]    idx;
   logic [CW-1:0] cnt;
   logic          sample;
   logic          accept;
   logic [7:0]    mask_smp;

   assign accept = (state == IDLE) && start;
   assign sample = (state == RUN) && (cnt == CNT_LAST);

   // Mask as it will look once the current vector's sample is written in.
   always_comb begin
      mask_smp      = mask;
      mask_smp[idx] = s_in;
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      {x, y, z} = 3'b000;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            busy      = 1'b1;
            {x, y, z} = idx;
            if (sample && (idx == 3'd7)) state_nxt = FINISH;
         end
         FINISH: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Vector index, settle counter, and result accumulation.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idx  <= 3'd0;
         cnt  <= '0;
         mask <= 8'h00;
         ones <= 4'd0;
      end else if (accept) begin
         idx  <= 3'd0;
         cnt  <= '0;
         mask <= 8'h00;
         ones <= 4'd0;
      end else if (state == RUN) begin
         if (sample) begin
            mask <= mask_smp;
            ones <= ones + {3'b000, s_in};
            cnt  <= '0;
            idx  <= idx + 3'd1;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

`ifdef FXYZ_CHECK_EN
   // Compare against the golden mask, including the final sample, so that
   // mismatch is valid in the same cycle as done.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                          mismatch <= 1'b0;
      else if (accept)                    mismatch <= 1'b0;
      else if (sample && (idx == 3'd7))   mismatch <= (mask_smp != EXPECT_MASK);
   end
`else
   // No comparator in this build. The expression folds to a constant 0 and
   // keeps the golden-mask parameter referenced.
   assign mismatch = 1'b0 & (^EXPECT_MASK);
`endif

endmodule
